// File: rtl/sw_capture_fifo.sv
// Switch capture path: 2-flop synchroniser, debouncer, and a DEPTH-entry history FIFO
// of accepted values. The LEDs show either the live stable value or the oldest logged entry.
module sw_capture_fifo #(
   parameter int WIDTH           = 10,
   parameter int DEPTH           = 8,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           sw,
   input  logic                       mode,
   input  logic                       pop,
   output logic [WIDTH-1:0]           led,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int CNTW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] sync1, sync2, candidate, stable;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic             settled, push, do_push, do_pop;

   // A value is accepted once the synchronised input has matched the candidate for
   // DEBOUNCE_CYCLES edges; it is logged only when it differs from the current stable value.
   assign settled = (sync2 == candidate) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
   assign push    = settled && (candidate != stable);

   // pop is a one-cycle request with no handshake back: it is honoured when the FIFO
   // holds data and silently ignored otherwise. A push into a full FIFO still lands
   // when a pop on the same edge frees the head slot.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   assign full  = (count == CNTW'(DEPTH));
   assign empty = (count == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1     <= '0;
         sync2     <= '0;
         candidate <= '0;
         stable    <= '0;
         cnt       <= '0;
      end else begin
         sync1 <= sw;
         sync2 <= sync1;
         if (sync2 != candidate) begin
            candidate <= sync2;
            cnt       <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            if (candidate != stable)
               stable <= candidate;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && do_push)
         mem[wr_ptr] <= candidate;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && full && !pop)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         led <= '0;
      else if (mode)
         led <= empty ? '0 : mem[rd_ptr];
      else
         led <= stable;
   end

endmodule
